// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: FSM encoding, cause codes
// and default geometry of the fetch PC.
package trap_controller_pkg;

    localparam int INSTRUCTION_DEPTH = 256;
    localparam int DEFAULT_PC_W      = $clog2(INSTRUCTION_DEPTH);
    localparam int DEFAULT_HANDLER_ADDR = 'h10;
    localparam int CAUSE_W_DEFAULT   = 5;

    typedef enum logic [2:0] {
        TRAP_IDLE    = 3'd0,
        TRAP_ENTER   = 3'd1,
        TRAP_HANDLER = 3'd2,
        TRAP_RETURN  = 3'd3,
        TRAP_HALT    = 3'd4
    } trap_state_t;

    // MSB flags an interrupt; low 4 bits carry the code.
    localparam logic [4:0] CAUSE_ILLEGAL  = 5'h02;
    localparam logic [4:0] CAUSE_MISALIGN = 5'h00;
    localparam logic [4:0] CAUSE_ECALL    = 5'h0B;
    localparam logic [4:0] CAUSE_IRQ_EXT  = 5'h1B;

endpackage

// File: rtl/trap_controller_priority_enc.sv
// Fixed-priority selection among pending trap sources:
// illegal > misalign > ecall > external interrupt.
module trap_priority_enc
    import trap_controller_pkg::*;
#(
    parameter int CAUSE_W = CAUSE_W_DEFAULT
) (
    input  logic               exc_illegal,
    input  logic               exc_misalign,
    input  logic               exc_ecall,
    input  logic               irq_req,
    output logic               event_valid,
    output logic               is_irq,
    output logic [CAUSE_W-1:0] cause
);

    always_comb begin
        event_valid = 1'b1;
        is_irq      = 1'b0;
        cause       = '0;
        if (exc_illegal) begin
            cause = CAUSE_W'(CAUSE_ILLEGAL);
        end else if (exc_misalign) begin
            cause = CAUSE_W'(CAUSE_MISALIGN);
        end else if (exc_ecall) begin
            cause = CAUSE_W'(CAUSE_ECALL);
        end else if (irq_req) begin
            cause  = CAUSE_W'(CAUSE_IRQ_EXT);
            is_irq = 1'b1;
        end else begin
            event_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Trap controller: captures exceptions/interrupts into EPC, redirects fetch
// to the handler and back on mret, and halts the core on a nested fault.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int              PC_W         = DEFAULT_PC_W,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(DEFAULT_HANDLER_ADDR),
    parameter int              CAUSE_W      = CAUSE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PC_W-1:0]    pc_current,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               exc_illegal,
    input  logic               exc_misalign,
    input  logic               exc_ecall,
    input  logic               irq_ext,
    input  logic               irq_en,
    input  logic               mret,
    input  logic [PC_W-1:0]    epc_out,
    output logic               epc_en,
    output logic [PC_W-1:0]    epc_in,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               flush,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               in_trap,
    output logic               halted
);

    trap_state_t        state_reg, state_next;
    logic [CAUSE_W-1:0] cause_reg;
    logic               cause_load;
    logic               evt_valid, evt_is_irq;
    logic [CAUSE_W-1:0] evt_cause;
    logic               exc_any;

    trap_priority_enc #(.CAUSE_W(CAUSE_W)) u_prio (
        .exc_illegal  (exc_illegal),
        .exc_misalign (exc_misalign),
        .exc_ecall    (exc_ecall),
        .irq_req      (irq_ext & irq_en),
        .event_valid  (evt_valid),
        .is_irq       (evt_is_irq),
        .cause        (evt_cause)
    );

    assign exc_any   = exc_illegal | exc_misalign | exc_ecall;
    assign cause_out = cause_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= TRAP_IDLE;
            cause_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (cause_load) begin
                cause_reg <= evt_cause;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cause_load     = 1'b0;
        epc_en         = 1'b0;
        epc_in         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b0;
        in_trap        = 1'b0;
        halted         = 1'b0;
        case (state_reg)
            TRAP_IDLE: begin
                // rstn gating keeps epc_en quiet while reset is held with flags up
                if (evt_valid && rstn) begin
                    epc_en     = 1'b1;
                    epc_in     = evt_is_irq ? pc_next : pc_current;
                    cause_load = 1'b1;
                    state_next = TRAP_ENTER;
                end
            end
            TRAP_ENTER: begin
                redirect_valid = 1'b1;
                redirect_pc    = HANDLER_ADDR;
                flush          = 1'b1;
                state_next     = TRAP_HANDLER;
            end
            TRAP_HANDLER: begin
                // Interrupts are masked here; a nested exception beats mret.
                in_trap = 1'b1;
                if (exc_any) begin
                    state_next = TRAP_HALT;
                end else if (mret) begin
                    state_next = TRAP_RETURN;
                end
            end
            TRAP_RETURN: begin
                redirect_valid = 1'b1;
                redirect_pc    = epc_out;
                flush          = 1'b1;
                in_trap        = 1'b1;
                state_next     = TRAP_IDLE;
            end
            TRAP_HALT: begin
                halted = 1'b1;
                flush  = 1'b1;
            end
            default: begin
                state_next = TRAP_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: table of single-event entries plus
// hand-written return, nested-fault and reset sequences.
module tb_trap_controller;

    localparam int PC_W    = 8;
    localparam int CAUSE_W = 5;

    logic               clk = 1'b0;
    logic               rstn;
    logic [PC_W-1:0]    pc_current, pc_next, epc_out;
    logic               exc_illegal, exc_misalign, exc_ecall, irq_ext, irq_en, mret;
    logic               epc_en;
    logic [PC_W-1:0]    epc_in;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               flush;
    logic [CAUSE_W-1:0] cause_out;
    logic               in_trap;
    logic               halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_controller dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .exc_illegal    (exc_illegal),
        .exc_misalign   (exc_misalign),
        .exc_ecall      (exc_ecall),
        .irq_ext        (irq_ext),
        .irq_en         (irq_en),
        .mret           (mret),
        .epc_out        (epc_out),
        .epc_en         (epc_en),
        .epc_in         (epc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .cause_out      (cause_out),
        .in_trap        (in_trap),
        .halted         (halted)
    );

    typedef struct {
        logic            ill, mis, ecl, irq, ien, mr;
        logic [PC_W-1:0] pcc, pcn;
        logic            exp_en;
        logic [PC_W-1:0] exp_in;
        logic [4:0]      exp_cause;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_illegal = 0; exc_misalign = 0; exc_ecall = 0;
        irq_ext = 0; irq_en = 0; mret = 0;
        pc_current = '0; pc_next = '0; epc_out = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Drives a single exception at pc and advances into HANDLER (sampled at negedges)
    task automatic enter_trap(input logic [PC_W-1:0] pc);
        @(negedge clk);
        exc_ecall = 1; pc_current = pc;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1,0,0,0,0,0, 8'h24, 8'h28, 1, 8'h24, 5'h02};
        vecs[1] = '{0,1,0,0,0,0, 8'h40, 8'h44, 1, 8'h40, 5'h00};
        vecs[2] = '{0,0,1,0,0,0, 8'h48, 8'h4C, 1, 8'h48, 5'h0B};
        vecs[3] = '{0,0,0,1,1,0, 8'h2C, 8'h30, 1, 8'h30, 5'h1B};
        vecs[4] = '{0,0,0,1,0,0, 8'h2C, 8'h30, 0, 8'h00, 5'h00};
        vecs[5] = '{0,0,1,1,1,0, 8'h50, 8'h54, 1, 8'h50, 5'h0B};
        vecs[6] = '{1,1,1,1,1,0, 8'h60, 8'h64, 1, 8'h60, 5'h02};
        vecs[7] = '{0,1,1,0,0,0, 8'h70, 8'h74, 1, 8'h70, 5'h00};
        vecs[8] = '{0,0,0,0,1,1, 8'h80, 8'h84, 0, 8'h00, 5'h00};
        vecs[9] = '{0,0,0,0,0,0, 8'h90, 8'h94, 0, 8'h00, 5'h00};

        clear_inputs();
        rstn = 1'b0;
        #2;
        check("reset_outputs",
              {28'd0, epc_en, redirect_valid, flush, in_trap},
              32'd0);
        check("reset_cause_halted", {26'd0, cause_out, halted}, 32'd0);

        // Single-event table: each entry from a fresh IDLE
        for (int i = 0; i < 10; i++) begin
            do_reset();
            @(negedge clk);
            exc_illegal = vecs[i].ill; exc_misalign = vecs[i].mis; exc_ecall = vecs[i].ecl;
            irq_ext = vecs[i].irq; irq_en = vecs[i].ien; mret = vecs[i].mr;
            pc_current = vecs[i].pcc; pc_next = vecs[i].pcn;
            #1;
            check($sformatf("v%0d_epc_en", i), {31'd0, epc_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("v%0d_epc_in", i), {24'd0, epc_in}, {24'd0, vecs[i].exp_in});
            @(negedge clk);
            clear_inputs();
            #1;
            check($sformatf("v%0d_cause", i), {27'd0, cause_out}, {27'd0, vecs[i].exp_cause});
            check($sformatf("v%0d_redirect", i),
                  {22'd0, redirect_valid, flush, redirect_pc},
                  vecs[i].exp_en ? 32'h0000_0310 : 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_in_trap", i), {31'd0, in_trap}, {31'd0, vecs[i].exp_en});
            $display("vector %0d: epc_en=%0d epc_in=0x%0h cause=0x%0h", i, vecs[i].exp_en,
                     vecs[i].exp_in, vecs[i].exp_cause);
        end

        // mret return; interrupt masked in HANDLER, taken in first IDLE after RETURN
        do_reset();
        @(negedge clk);
        exc_illegal = 1; pc_current = 8'h24;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        irq_ext = 1; irq_en = 1; pc_next = 8'h38; epc_out = 8'h24;
        #1;
        check("handler_irq_masked", {31'd0, epc_en}, 32'd0);
        check("handler_in_trap", {31'd0, in_trap}, 32'd1);
        mret = 1;
        @(negedge clk);
        mret = 0;
        #1;
        check("return_redirect",
              {21'd0, redirect_valid, flush, in_trap, redirect_pc},
              32'h0000_0724);
        check("return_epc_en", {31'd0, epc_en}, 32'd0);
        check("return_cause_held", {27'd0, cause_out}, 32'h02);
        @(negedge clk);
        #1;
        check("idle_after_return", {30'd0, in_trap, redirect_valid}, 32'd0);
        check("pending_irq_epc", {23'd0, epc_en, epc_in}, 32'h0000_0138);
        @(negedge clk);
        clear_inputs();
        #1;
        check("pending_irq_cause", {27'd0, cause_out}, 32'h1B);
        $display("sequence mret/return done");

        // Nested fault with simultaneous mret goes to HALT and stays there
        do_reset();
        enter_trap(8'h44);
        exc_misalign = 1; mret = 1; pc_current = 8'h48; epc_out = 8'h44;
        @(negedge clk);
        #1;
        check("halt_entry", {29'd0, halted, flush, redirect_valid}, 32'd6);
        for (int c = 0; c < 22; c++) begin
            exc_illegal = c[0]; mret = c[1]; irq_ext = 1; irq_en = 1;
            @(negedge clk);
            #1;
            check($sformatf("halt_hold_%0d", c), {29'd0, halted, epc_en, in_trap}, 32'd4);
        end
        rstn = 1'b0;
        #1;
        check("halt_cleared_by_reset", {28'd0, halted, flush, epc_en, redirect_valid}, 32'd0);
        $display("sequence nested fault done");

        // Reset pulsed between clock edges while in HANDLER
        do_reset();
        enter_trap(8'h20);
        #1;
        check("pre_reset_in_trap", {31'd0, in_trap}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midtrap_reset_outputs",
              {22'd0, epc_en, redirect_valid, flush, in_trap, halted, cause_out},
              32'd0);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("midtrap_reset_idle", {30'd0, in_trap, redirect_valid}, 32'd0);
        exc_ecall = 1; pc_current = 8'h5C;
        #1;
        check("midtrap_reset_idle_accepts", {23'd0, epc_en, epc_in}, 32'h0000_015C);
        clear_inputs();
        $display("sequence mid-trap reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Control stage directly upstream of the EPC register: detects exceptions and interrupts, and drives EPC's load enable and data input.
- Also redirects fetch to the trap handler, and on mret redirects fetch back to the saved EPC value.
- Sits between the execute/decode exception flags and the fetch PC mux.
- Holds the trap cause for the handler and halts the core on a nested fault.

Parameters:
- PC_W, $clog2(`INSTRUCTION_DEPTH), PC width; must equal the EPC width.
- HANDLER_ADDR, 'h10 (PC_W bits), trap vector address.
- CAUSE_W, 5, cause width; MSB is the interrupt flag, low 4 bits are the code.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pc_current  in  PC_W  PC of the instruction raising the exception.
- pc_next  in  PC_W  PC of the next instruction to retire (interrupt return point).
- exc_illegal  in  1  illegal-instruction flag.
- exc_misalign  in  1  misaligned-fetch flag.
- exc_ecall  in  1  ecall flag.
- irq_ext  in  1  external interrupt, level-sensitive.
- irq_en  in  1  global interrupt enable.
- mret  in  1  mret decoded in the handler.
- epc_out  in  PC_W  current EPC contents.
- epc_en  out  1  EPC load enable, combinational.
- epc_in  out  PC_W  EPC load data, combinational.
- redirect_valid  out  1  fetch must take redirect_pc this cycle.
- redirect_pc  out  PC_W  redirect target.
- flush  out  1  kill in-flight instructions.
- cause_out  out  CAUSE_W  registered trap cause.
- in_trap  out  1  handler is executing.
- halted  out  1  nested fault; core stalled.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, cause_out=0.
  - All outputs 0, including epc_en, redirect_valid, flush, in_trap and halted.
- Event priority: exc_illegal > exc_misalign > exc_ecall > (irq_ext & irq_en).
- Cause codes:
  - illegal = 5'h02, misalign = 5'h00, ecall = 5'h0B, irq = 5'h1B (MSB set).
- IDLE state:
  - Any event: epc_en=1 in the same cycle.
  - epc_in = pc_current for exceptions, pc_next for the interrupt.
  - At that posedge EPC loads, cause_out loads, and state goes to ENTER.
  - No event: epc_en=0 and epc_in=0.
  - mret in IDLE is ignored.
- ENTER state (exactly 1 cycle):
  - redirect_valid=1, redirect_pc=HANDLER_ADDR, flush=1.
  - Inputs are ignored; next state is HANDLER.
- HANDLER state:
  - in_trap=1, and interrupts are masked regardless of irq_en.
  - Any exception flag goes to HALT. This wins over a simultaneous mret.
  - mret alone goes to RETURN.
  - epc_en stays 0 throughout.
- RETURN state (exactly 1 cycle):
  - redirect_valid=1, redirect_pc=epc_out, flush=1, in_trap=1.
  - Next state is IDLE; cause_out is held.
  - Inputs are ignored in RETURN. A pending irq is evaluated in the first IDLE cycle after RETURN.
- HALT state:
  - halted=1, flush=1, redirect_valid=0.
  - Exits only on reset.
- Latency:
  - Event cycle N: EPC is written at the end of N.
  - Handler redirect occurs in N+1; the first handler fetch is in N+2.
  - mret in cycle M: return redirect occurs in M+1.
- The controller never reads epc_out except in RETURN.
- Reset mid-trap returns to IDLE immediately; EPC contents are the EPC block's concern.
- Outputs not driven by a state are 0. No latches; next-state and output decode are fully combinational.

Decomposition:
- Add to parameters.v:
  - state encodings TRAP_IDLE/ENTER/HANDLER/RETURN/HALT (3-bit);
  - cause constants CAUSE_ILLEGAL, CAUSE_MISALIGN, CAUSE_ECALL, CAUSE_IRQ_EXT;
  - default HANDLER_ADDR.
- One natural sub-module: trap_priority_enc.
  - Combinational; takes the four event flags.
  - Outputs event_valid, is_irq and cause.
- The top level holds the FSM, the cause register and the output decode.
- The top level also instantiates EPC in integration.

Test Plan:
- Reset mid-HANDLER (rstn pulsed low between clk edges) -> all outputs 0 immediately; state IDLE on the next cycle.
- exc_illegal=1, pc_current='h24 in cycle N:
  - N: epc_en=1, epc_in='h24.
  - N+1: cause_out=5'h02, redirect_valid=1, redirect_pc='h10, flush=1.
  - N+2: in_trap=1.
- irq_ext=1, irq_en=1, pc_next='h30, no exceptions:
  - epc_in='h30, cause_out=5'h1B.
  - Same with irq_en=0 -> epc_en stays 0.
- exc_ecall and irq_ext asserted together -> ecall wins: cause_out=5'h0B, epc_in=pc_current.
- In HANDLER with epc_out='h24, mret=1 -> next cycle redirect_valid=1, redirect_pc='h24, flush=1; then IDLE with in_trap=0.
- In HANDLER, exc_misalign=1 and mret=1 together -> HALT: halted=1 held for 20+ cycles; epc_en never pulses; rstn low clears halted.
